// File: rtl/flash_sample_reader_if.sv
// flash_sample_reader_if: Avalon-MM read port between the sample reader and the on-board flash
interface flash_sample_reader_if #(
    parameter int ADDR_W = 23
);
    logic              flash_mem_read;
    logic [ADDR_W-1:0] flash_mem_address;
    logic [3:0]        flash_mem_byteenable;
    logic              flash_mem_waitrequest;
    logic [31:0]       flash_mem_readdata;
    logic              flash_mem_readdatavalid;

    modport master (
        output flash_mem_read, flash_mem_address, flash_mem_byteenable,
        input  flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid
    );

    modport slave (
        input  flash_mem_read, flash_mem_address, flash_mem_byteenable,
        output flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid
    );
endinterface

// File: rtl/flash_sample_reader.sv
// flash_sample_reader: fetches 32-bit flash words and plays their two upper-byte samples on sample ticks
module flash_sample_reader #(
    parameter int ADDR_W   = 23,
    parameter int SAMPLE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  forward,
    input  logic                  sample_tick,
    input  logic [ADDR_W-1:0]     address,
    output logic                  addr_advance,
    flash_sample_reader_if.master mem,
    output logic [SAMPLE_W-1:0]   audio_data,
    output logic                  audio_valid
);
    typedef enum logic [2:0] {IDLE, READ_REQ, READ_WAIT, FIRST_HALF, SECOND_HALF, ADVANCE} state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic [31:0]         word, word_n;
    logic                dir, dir_n;
    logic [SAMPLE_W-1:0] data_n, lo_s, hi_s;
    logic                valid_n, play, unused_word;

    assign play        = sample_tick & enable;
    assign lo_s        = word[15 -: SAMPLE_W];
    assign hi_s        = word[31 -: SAMPLE_W];
    assign unused_word = ^{word[23:16], word[7:0]};

    assign addr_advance             = state == ADVANCE;
    assign mem.flash_mem_read       = state == READ_REQ;
    assign mem.flash_mem_address    = addr_q;
    assign mem.flash_mem_byteenable = 4'b1111;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            addr_q      <= '0;
            word        <= '0;
            dir         <= 1'b0;
            audio_data  <= '0;
            audio_valid <= 1'b0;
        end else begin
            state       <= state_n;
            addr_q      <= addr_n;
            word        <= word_n;
            dir         <= dir_n;
            audio_data  <= data_n;
            audio_valid <= valid_n;
        end
    end

    // Direction is latched with the word so a mid-word change only affects the next word
    always_comb begin
        state_n = state;
        addr_n  = addr_q;
        word_n  = word;
        dir_n   = dir;
        data_n  = audio_data;
        valid_n = 1'b0;
        case (state)
            IDLE: begin
                addr_n  = enable ? address : addr_q;
                state_n = enable ? READ_REQ : IDLE;
            end
            READ_REQ: state_n = mem.flash_mem_waitrequest ? READ_REQ : READ_WAIT;
            READ_WAIT: begin
                if (mem.flash_mem_readdatavalid) begin
                    word_n  = mem.flash_mem_readdata;
                    dir_n   = forward;
                    state_n = FIRST_HALF;
                end
            end
            FIRST_HALF: begin
                if (play) begin
                    data_n  = dir ? lo_s : hi_s;
                    valid_n = 1'b1;
                    state_n = SECOND_HALF;
                end
            end
            SECOND_HALF: begin
                if (play) begin
                    data_n  = dir ? hi_s : lo_s;
                    valid_n = 1'b1;
                    state_n = ADVANCE;
                end
            end
            ADVANCE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_flash_sample_reader.sv
// tb_flash_sample_reader: directed playback scenarios checked against a sample-queue model of the reader
module tb_flash_sample_reader;
    logic        clk = 0, reset = 1, enable = 0, forward = 0, sample_tick = 0;
    logic [22:0] address = 0;
    logic        addr_advance, audio_valid;
    logic [7:0]  audio_data;

    flash_sample_reader_if #(.ADDR_W(23)) m();

    flash_sample_reader dut (
        .clk(clk), .reset(reset), .enable(enable), .forward(forward),
        .sample_tick(sample_tick), .address(address), .addr_advance(addr_advance),
        .mem(m), .audio_data(audio_data), .audio_valid(audio_valid)
    );

    always #5 clk = ~clk;

    int          total = 0, bad = 0;
    int          stall_cfg = 0, rsp_lat = 3, nvalid = 0, nadv = 0;
    logic [31:0] rsp_word = 0;
    bit          glitch = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Flash slave: stalls each request stall_cfg cycles, answers rsp_lat cycles after acceptance
    initial begin
        int  cnt;
        bit  seen;
        cnt  = 0;
        seen = 0;
        m.flash_mem_waitrequest   = 0;
        m.flash_mem_readdata      = 0;
        m.flash_mem_readdatavalid = 0;
        forever begin
            @(posedge clk); #1;
            if (glitch) begin
                m.flash_mem_waitrequest   = ~m.flash_mem_waitrequest;
                m.flash_mem_readdatavalid = ~m.flash_mem_readdatavalid;
                m.flash_mem_readdata      = ~m.flash_mem_readdata;
            end else if (m.flash_mem_read) begin
                if (!seen) begin
                    seen = 1;
                    cnt  = stall_cfg;
                end
                if (cnt > 0) begin
                    m.flash_mem_waitrequest = 1;
                    cnt--;
                end else begin
                    m.flash_mem_waitrequest = 0;
                    seen = 0;
                    repeat (rsp_lat) @(posedge clk);
                    #1;
                    m.flash_mem_readdata      = rsp_word;
                    m.flash_mem_readdatavalid = 1;
                    @(posedge clk); #1;
                    m.flash_mem_readdatavalid = 0;
                end
            end else begin
                seen = 0;
                m.flash_mem_waitrequest   = 0;
                m.flash_mem_readdatavalid = 0;
            end
        end
    end

    // Model: each returned word becomes two queued samples, released one per enabled tick
    logic [8:0]  q[$];
    logic [31:0] w;
    logic [7:0]  last;
    logic [22:0] exp_addr;
    bit          exp_valid, busy, awaiting, rd_start, popped2;
    int          rd_cnt;

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_read", m.flash_mem_read, 0);
            chk("rst_addr", m.flash_mem_address, 0);
            chk("rst_data", audio_data, 0);
            chk("rst_valid", audio_valid, 0);
            chk("rst_adv", addr_advance, 0);
            q.delete();
            exp_valid = 0; busy = 0; awaiting = 0; rd_start = 0; rd_cnt = 0; last = 0;
        end else begin
            popped2 = 0;
            if (audio_valid) nvalid++;
            if (addr_advance) nadv++;
            chk("valid", audio_valid, exp_valid);
            if (exp_valid && q.size() > 0) {popped2, last} = q.pop_front();
            chk("data", audio_data, last);
            chk("adv", addr_advance, popped2);
            if (rd_start) chk("read_start", m.flash_mem_read, 1);
            rd_start = 0;
            if (m.flash_mem_read) begin
                chk("req_addr", m.flash_mem_address, exp_addr);
                rd_cnt++;
            end else if (rd_cnt != 0) begin
                chk("read_len", rd_cnt, stall_cfg + 1);
                rd_cnt = 0;
            end
            if (m.flash_mem_read && !m.flash_mem_waitrequest) awaiting = 1;
            exp_valid = sample_tick && enable && q.size() > 0;
            if (m.flash_mem_readdatavalid && awaiting) begin
                w = m.flash_mem_readdata;
                q.push_back({1'b0, forward ? w[15:8] : w[31:24]});
                q.push_back({1'b1, forward ? w[31:24] : w[15:8]});
                awaiting = 0;
            end
            if (!busy && enable) begin
                busy = 1;
                exp_addr = address;
                rd_start = 1;
            end else if (popped2) busy = 0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sample_tick = 1;
        cyc(1);
        sample_tick = 0;
    endtask

    task automatic wait_valid(input string name, input logic [7:0] exp);
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = audio_valid;
        end
        if (!got) chk({name, "_timeout"}, 0, 1);
        else chk(name, audio_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_hi, nv;
        cyc(2);
        glitch = 1; enable = 1; forward = 1; sample_tick = 1; address = '1;
        cyc(1);
        enable = 0; sample_tick = 0; address = 0;
        cyc(1);
        enable = 1; sample_tick = 1;
        cyc(1);
        chk("glitch_read", m.flash_mem_read, 0);
        chk("glitch_data", audio_data, 0);
        chk("glitch_adv", addr_advance, 0);
        glitch = 0; enable = 0; sample_tick = 0; forward = 0; address = 0;
        cyc(2);
        reset = 0;
        rd_hi = 0;
        repeat (20) begin
            @(negedge clk);
            if (m.flash_mem_read) rd_hi++;
        end
        chk("idle_no_read", rd_hi, 0);
        // forward playback
        cyc(1);
        address = 23'h10; forward = 1; rsp_word = 32'h11223344; rsp_lat = 3; enable = 1;
        cyc(1);
        @(negedge clk);
        chk("fwd_read", m.flash_mem_read, 1);
        chk("fwd_addr", m.flash_mem_address, 23'h10);
        cyc(8);
        tick();
        wait_valid("fwd_s0", 8'h33);
        cyc(1);
        tick();
        enable = 0;
        wait_valid("fwd_s1", 8'h11);
        chk("fwd_adv", addr_advance, 1);
        // reverse playback with a direction flip between ticks
        cyc(3);
        address = 23'h20; forward = 0; enable = 1;
        cyc(10);
        tick();
        wait_valid("rev_s0", 8'h11);
        cyc(1);
        forward = 1;
        tick();
        enable = 0;
        wait_valid("rev_s1", 8'h33);
        // waitrequest stall with the input address moving underneath
        cyc(3);
        address = 23'h30; stall_cfg = 3; rsp_word = 32'hA5B6C7D8; enable = 1;
        cyc(2);
        address = 23'h55;
        @(negedge clk);
        chk("stall_read", m.flash_mem_read, 1);
        chk("stall_addr", m.flash_mem_address, 23'h30);
        cyc(12);
        stall_cfg = 0;
        tick();
        wait_valid("stall_s0", 8'hC7);
        cyc(1);
        tick();
        enable = 0;
        wait_valid("stall_s1", 8'hA5);
        // pause in the second half
        cyc(3);
        address = 23'h40; rsp_word = 32'h80FF7F01; enable = 1;
        cyc(10);
        tick();
        wait_valid("pause_s0", 8'h7F);
        cyc(1);
        enable = 0;
        nv = nvalid;
        repeat (5) begin
            tick();
            cyc(1);
        end
        chk("pause_novalid", nvalid, nv);
        chk("pause_hold", audio_data, 8'h7F);
        enable = 1;
        tick();
        enable = 0;
        wait_valid("pause_s1", 8'h80);
        chk("pause_adv", addr_advance, 1);
        cyc(1);
        chk("adv_count", nadv, 4);
        // asynchronous reset while a request is stalled
        cyc(3);
        address = 23'h60; stall_cfg = 5; enable = 1;
        cyc(2);
        reset = 1;
        #1;
        chk("async_rst_read", m.flash_mem_read, 0);
        chk("async_rst_addr", m.flash_mem_address, 0);
        enable = 0; stall_cfg = 0;
        cyc(2);
        reset = 0;
        // reset in READ_WAIT, late readdatavalid must be discarded
        cyc(2);
        address = 23'h70; rsp_word = 32'hFFFFFFFF; rsp_lat = 6; enable = 1;
        cyc(3);
        reset = 1; enable = 0;
        cyc(1);
        reset = 0;
        cyc(12);
        chk("late_rdv_data", audio_data, 0);
        chk("late_rdv_read", m.flash_mem_read, 0);
        chk("late_rdv_nvalid", nvalid, 8);
        enable = 1;
        cyc(1);
        @(negedge clk);
        chk("idle_after_rst", m.flash_mem_read, 1);
        cyc(1);
        enable = 0;
        cyc(12);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
